alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised, registered ALU with an integrated ALUOp/Funct decoder and an iterative multiply/divide unit with HI/LO registers. It sits in the execute stage of the MIPS datapath, takes ALUOp from the main control decoder plus the R-type Funct/shamt fields, and produces a registered result. Unlike a purely combinational ALU decoder, it covers the full R-type arithmetic set, multi-cycle mult/div with a valid/ready handshake, and an illegal-funct flag.

## Interface
- WIDTH, 32: operand/result width (≥8, power of two).
- SHW, $clog2(WIDTH): shift-amount width.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; low while mult/div in progress.
- ALUOp  in  2  00 add, 01/11 sub (branch compare), 10 decode Funct.
- Funct  in  6  R-type function field.
- shamt  in  SHW  shift amount for sll/srl/sra.
- a, b  in  WIDTH  operands (rs, rt).
- out_valid  out  1  one-cycle pulse, result fields valid.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- ovf  out  1  signed overflow, add/sub only (informational, no trap).
- illegal  out  1  ALUOp=10 with unsupported Funct.
- hi, lo  out  WIDTH  architectural HI/LO registers.

## Operation
- Accept = in_valid & in_ready. Inputs sampled only on accept.
- ALUOp 00: a+b. 01 and 11: a−b. 10: Funct decode:
  - 0x00 sll b<<shamt; 0x02 srl; 0x03 sra (arithmetic, on b).
  - 0x10 mfhi → hi; 0x12 mflo → lo.
  - 0x18 mult, 0x19 multu: {hi,lo} ← a×b (signed/unsigned), 2·WIDTH-bit product.
  - 0x1A div, 0x1B divu: lo ← quotient, hi ← remainder; signed: quotient truncates toward zero, remainder takes sign of a.
  - 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor; 0x2A slt (signed); 0x2B sltu.
  - Any other Funct: result 0, illegal=1, hi/lo unchanged.
- Divide by zero: no trap; lo ← all ones, hi ← a; fixed latency unchanged.
- mult/div result output = new lo value; zero computed on it.
- ovf only for ALUOp 00/01/11 and Funct 0x20/0x22; 0 otherwise.
- FSM: IDLE → (accept single-cycle op) IDLE; IDLE → (accept mult/div) BUSY; BUSY counts WIDTH iterations (shift-add / restoring divide on magnitudes) → FIX (sign correction, HI/LO write, out_valid) → IDLE.

## Timing
- Reset: result, hi, lo = 0; out_valid, ovf, illegal = 0; zero = 1; FSM IDLE; in_ready = 1.
- Single-cycle ops: out_valid one cycle after accept; back-to-back accepts every cycle.
- mult/div: in_ready falls the cycle after accept; out_valid exactly WIDTH+2 cycles after accept; in_ready rises with out_valid, so a new op may be accepted in the same cycle out_valid is high.
- mfhi/mflo accepted the cycle out_valid of a mult/div is high returns the updated hi/lo.
- in_valid while in_ready=0: ignored, no state change; requester holds.
- No output back-pressure; out_valid is a single-cycle pulse, and result/flags hold until the next out_valid.
- rst_n asserted mid mult/div: aborts immediately, hi/lo return to 0, no out_valid.

## Structure
- Package alu_pkg: Funct localparams, 4-bit ALU control encodings (extending 010 add, 110 sub, 000 and, 001 or, 111 slt), FSM state enum.
- Sub-module mdu_iter: iterative mult/div datapath and counter; top holds decoder, single-cycle ALU, FSM, HI/LO.

## Test plan
- Reset mid-op: accept mult with a=3, b=5, assert rst_n low at cycle 4 → out_valid never pulses, hi=lo=0, in_ready=1.
- ALUOp=10, Funct 0x2A, a=0xFFFFFFFF, b=1 → result 1; same inputs with 0x2B → result 0; one cycle latency each, back-to-back.
- ALUOp=00, a=0x7FFFFFFF, b=1 → result 0x80000000, ovf=1, zero=0; ALUOp=01, a=b=5 → result 0, zero=1.
- mult a=−3, b=7 → after 34 cycles lo=0xFFFFFFEB, hi=0xFFFFFFFF; then mfhi in the out_valid cycle → result 0xFFFFFFFF.
- div a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 → lo=0xFFFFFFFF, hi=7, same latency; in_valid during BUSY ignored.
- Funct 0x3F with ALUOp=10 → result 0, illegal=1, hi/lo unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU/MDU: Funct codes, ALU control, FSM states, decoder.
package alu_pkg;

  // ALUOp from the main control decoder
  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_FUNCT = 2'b10;
  localparam logic [1:0] OP_SUB2  = 2'b11;

  // R-type Funct field values
  localparam logic [5:0] F_SLL   = 6'h00;
  localparam logic [5:0] F_SRL   = 6'h02;
  localparam logic [5:0] F_SRA   = 6'h03;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_ADDU  = 6'h21;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_SUBU  = 6'h23;
  localparam logic [5:0] F_AND   = 6'h24;
  localparam logic [5:0] F_OR    = 6'h25;
  localparam logic [5:0] F_XOR   = 6'h26;
  localparam logic [5:0] F_NOR   = 6'h27;
  localparam logic [5:0] F_SLT   = 6'h2A;
  localparam logic [5:0] F_SLTU  = 6'h2B;

  // 4-bit ALU control; the classic 3-bit codes keep their values with a leading 0
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_ZERO = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;
  localparam logic [3:0] ALU_MFHI = 4'b1011;
  localparam logic [3:0] ALU_MFLO = 4'b1100;
  localparam logic [3:0] ALU_SLTU = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_FIX  = 2'b10
  } state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       is_mdu;
    logic       mdu_div;
    logic       mdu_signed;
    logic       ovf_en;
    logic       illegal;
  } dec_t;

  // ALUOp/Funct decode; mult/div leave ctrl at ALU_ZERO since the MDU supplies the result
  function automatic dec_t alu_decode(input logic [1:0] aluop, input logic [5:0] funct);
    dec_t d;
    d      = '0;
    d.ctrl = ALU_ZERO;
    case (aluop)
      OP_ADD: begin
        d.ctrl   = ALU_ADD;
        d.ovf_en = 1'b1;
      end
      OP_SUB, OP_SUB2: begin
        d.ctrl   = ALU_SUB;
        d.ovf_en = 1'b1;
      end
      default: begin
        case (funct)
          F_SLL:   d.ctrl = ALU_SLL;
          F_SRL:   d.ctrl = ALU_SRL;
          F_SRA:   d.ctrl = ALU_SRA;
          F_MFHI:  d.ctrl = ALU_MFHI;
          F_MFLO:  d.ctrl = ALU_MFLO;
          F_MULT: begin
            d.is_mdu     = 1'b1;
            d.mdu_signed = 1'b1;
          end
          F_MULTU: d.is_mdu = 1'b1;
          F_DIV: begin
            d.is_mdu     = 1'b1;
            d.mdu_div    = 1'b1;
            d.mdu_signed = 1'b1;
          end
          F_DIVU: begin
            d.is_mdu  = 1'b1;
            d.mdu_div = 1'b1;
          end
          F_ADD: begin
            d.ctrl   = ALU_ADD;
            d.ovf_en = 1'b1;
          end
          F_ADDU:  d.ctrl = ALU_ADD;
          F_SUB: begin
            d.ctrl   = ALU_SUB;
            d.ovf_en = 1'b1;
          end
          F_SUBU:  d.ctrl = ALU_SUB;
          F_AND:   d.ctrl = ALU_AND;
          F_OR:    d.ctrl = ALU_OR;
          F_XOR:   d.ctrl = ALU_XOR;
          F_NOR:   d.ctrl = ALU_NOR;
          F_SLT:   d.ctrl = ALU_SLT;
          F_SLTU:  d.ctrl = ALU_SLTU;
          default: d.illegal = 1'b1;
        endcase
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative multiply/divide datapath: shift-add multiply and restoring divide on magnitudes,
// followed by a registered sign-correction step.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             run_i,
  input  logic             div_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  // acc holds {hi, lo} of the running product, or {remainder, quotient/dividend} when dividing
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             div_q, div_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             bz_q, bz_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;

  logic [WIDTH-1:0] neg_a_c, neg_b_c, mag_a_c, mag_b_c;
  logic [WIDTH:0]   mul_sum_c;
  logic [WIDTH:0]   trial_c;
  logic [AW-1:0]    prod_neg_c;
  logic [WIDTH-1:0] quo_neg_c, rem_neg_c;

  assign neg_a_c    = -a_i;
  assign neg_b_c    = -b_i;
  assign mag_a_c    = (signed_i && a_i[WIDTH-1]) ? neg_a_c : a_i;
  assign mag_b_c    = (signed_i && b_i[WIDTH-1]) ? neg_b_c : b_i;
  assign mul_sum_c  = {1'b0, acc_q[AW-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
  assign trial_c    = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, m_q};
  assign prod_neg_c = -acc_q;
  assign quo_neg_c  = -acc_q[WIDTH-1:0];
  assign rem_neg_c  = -acc_q[AW-1:WIDTH];

  // Load on start, WIDTH iteration steps, then one sign-correction step
  always_comb begin
    acc_d    = acc_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    bz_d     = bz_q;
    last_d   = last_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    if (start_i) begin
      div_d  = div_i;
      neg_d  = signed_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_d = signed_i & a_i[WIDTH-1];
      bz_d   = (b_i == '0);
      acc_d  = div_i ? {WIDTH'(0), mag_a_c} : {WIDTH'(0), mag_b_c};
      m_d    = div_i ? mag_b_c : mag_a_c;
      cnt_d  = '0;
      last_d = 1'b0;
    end else if (run_i) begin
      if (!last_q) begin
        if (div_q) begin
          if (!trial_c[WIDTH]) begin
            acc_d = {trial_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[AW-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
        end
        cnt_d  = cnt_q + CW'(1);
        last_d = (cnt_q == CW'(WIDTH - 1));
      end else begin
        last_d = 1'b0;
        if (div_q) begin
          res_lo_d = bz_q ? '1 : (neg_q ? quo_neg_c : acc_q[WIDTH-1:0]);
          res_hi_d = rneg_q ? rem_neg_c : acc_q[AW-1:WIDTH];
        end else begin
          res_hi_d = neg_q ? prod_neg_c[AW-1:WIDTH] : acc_q[AW-1:WIDTH];
          res_lo_d = neg_q ? prod_neg_c[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
      end
    end
  end

  // Datapath and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      last_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      acc_q    <= acc_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      bz_q     <= bz_d;
      last_q   <= last_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
    end
  end

  assign last_o = last_q;
  assign hi_o   = res_hi_q;
  assign lo_o   = res_lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with ALUOp/Funct decode, registered result/flags and an iterative MDU with HI/LO.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       Funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  dec_t             dec_c;
  logic             accept_c;
  logic             mdu_start_c;
  logic             mdu_run_c;
  logic             mdu_last;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;
  logic [WIDTH-1:0] sum_c, diff_c, alu_res_c;
  logic             ovf_add_c, ovf_sub_c, ovf_c;

  assign dec_c     = alu_decode(ALUOp, Funct);
  assign accept_c  = in_valid & ready_q;
  assign mdu_run_c = (state_q == ST_BUSY);

  assign sum_c     = a + b;
  assign diff_c    = a - b;
  assign ovf_add_c = (a[WIDTH-1] == b[WIDTH-1]) & (sum_c[WIDTH-1] != a[WIDTH-1]);
  assign ovf_sub_c = (a[WIDTH-1] != b[WIDTH-1]) & (diff_c[WIDTH-1] != a[WIDTH-1]);
  assign ovf_c     = dec_c.ovf_en & ((dec_c.ctrl == ALU_SUB) ? ovf_sub_c : ovf_add_c);

  // Single-cycle ALU result selected by the decoded control
  always_comb begin
    alu_res_c = '0;
    case (dec_c.ctrl)
      ALU_AND:  alu_res_c = a & b;
      ALU_OR:   alu_res_c = a | b;
      ALU_ADD:  alu_res_c = sum_c;
      ALU_XOR:  alu_res_c = a ^ b;
      ALU_NOR:  alu_res_c = ~(a | b);
      ALU_SUB:  alu_res_c = diff_c;
      ALU_SLT:  alu_res_c = WIDTH'($signed(a) < $signed(b));
      ALU_SLTU: alu_res_c = WIDTH'(a < b);
      ALU_SLL:  alu_res_c = b << shamt;
      ALU_SRL:  alu_res_c = b >> shamt;
      ALU_SRA:  alu_res_c = WIDTH'($signed(b) >>> shamt);
      ALU_MFHI: alu_res_c = hi_q;
      ALU_MFLO: alu_res_c = lo_q;
      default:  alu_res_c = '0;
    endcase
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_mdu (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (mdu_start_c),
    .run_i    (mdu_run_c),
    .div_i    (dec_c.mdu_div),
    .signed_i (dec_c.mdu_signed),
    .a_i      (a),
    .b_i      (b),
    .last_o   (mdu_last),
    .hi_o     (mdu_hi),
    .lo_o     (mdu_lo)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c && dec_c.is_mdu) state_d = ST_BUSY;
      ST_BUSY: if (mdu_last) state_d = ST_FIX;
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values of the result, flags and HI/LO
  always_comb begin
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    out_valid_d = 1'b0;
    mdu_start_c = 1'b0;
    ready_d     = (state_d == ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (dec_c.is_mdu) begin
            mdu_start_c = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            result_d    = alu_res_c;
            zero_d      = (alu_res_c == '0);
            ovf_d       = ovf_c;
            illegal_d   = dec_c.illegal;
          end
        end
      end
      ST_FIX: begin
        out_valid_d = 1'b1;
        hi_d        = mdu_hi;
        lo_d        = mdu_lo;
        result_d    = mdu_lo;
        zero_d      = (mdu_lo == '0);
        ovf_d       = 1'b0;
        illegal_d   = 1'b0;
      end
      default: ;
    endcase
  end

  // Result, flag and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: hand-computed vectors, latency and handshake checks.
module tb_alu_mdu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  ALUOp;
  logic [5:0]  Funct;
  logic [4:0]  shamt;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        zero;
  logic        ovf;
  logic        illegal;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  alu_mdu #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ALUOp    (ALUOp),
    .Funct    (Funct),
    .shamt    (shamt),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf),
    .illegal  (illegal),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Present one op for exactly one accept edge; returns #1 after that edge
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] x, input logic [31:0] y);
    ALUOp    = op;
    Funct    = f;
    shamt    = sh;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 100);
  endtask

  logic [5:0]  lf [4];
  logic [31:0] le [4];
  int          n;
  int          pulses;

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    ALUOp    = 2'b00;
    Funct    = 6'h00;
    shamt    = 5'd0;
    a        = 32'h0;
    b        = 32'h0;
    lf[0] = 6'h24; le[0] = 32'h00F0_1200;
    lf[1] = 6'h25; le[1] = 32'hFFF0_FF34;
    lf[2] = 6'h26; le[2] = 32'hFF00_ED34;
    lf[3] = 6'h27; le[3] = 32'h000F_00CB;

    // reset values
    #12;
    check_eq("rst_result", result, 32'h0);
    check_eq("rst_hi", hi, 32'h0);
    check_eq("rst_lo", lo, 32'h0);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    check_eq("rst_ovf", 32'(ovf), 32'h0);
    check_eq("rst_illegal", 32'(illegal), 32'h0);
    check_eq("rst_zero", 32'(zero), 32'h1);
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // slt then sltu back-to-back
    ALUOp = 2'b10; Funct = 6'h2A; a = 32'hFFFF_FFFF; b = 32'h1; in_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("slt_valid", 32'(out_valid), 32'h1);
    check_eq("slt_result", result, 32'h1);
    Funct = 6'h2B;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("sltu_valid", 32'(out_valid), 32'h1);
    check_eq("sltu_result", result, 32'h0);
    check_eq("sltu_zero", 32'(zero), 32'h1);
    @(posedge clk); #1;
    check_eq("pulse_drop", 32'(out_valid), 32'h0);
    check_eq("result_hold", result, 32'h0);

    // add overflow, sub to zero
    issue(2'b00, 6'h00, 5'd0, 32'h7FFF_FFFF, 32'h1);
    check_eq("add_result", result, 32'h8000_0000);
    check_eq("add_ovf", 32'(ovf), 32'h1);
    check_eq("add_zero", 32'(zero), 32'h0);
    issue(2'b01, 6'h00, 5'd0, 32'h5, 32'h5);
    check_eq("sub_result", result, 32'h0);
    check_eq("sub_zero", 32'(zero), 32'h1);
    check_eq("sub_ovf", 32'(ovf), 32'h0);
    issue(2'b10, 6'h21, 5'd0, 32'h7FFF_FFFF, 32'h1);
    check_eq("addu_ovf", 32'(ovf), 32'h0);

    // logic ops and shifts
    for (int i = 0; i < 4; i++) begin
      issue(2'b10, lf[i], 5'd0, 32'hF0F0_1234, 32'h0FF0_FF00);
      check_eq("logic_op", result, le[i]);
    end
    issue(2'b10, 6'h03, 5'd4, 32'h0, 32'h8000_0000);
    check_eq("sra", result, 32'hF800_0000);
    issue(2'b10, 6'h02, 5'd4, 32'h0, 32'h8000_0000);
    check_eq("srl", result, 32'h0800_0000);
    issue(2'b10, 6'h00, 5'd31, 32'h0, 32'h1);
    check_eq("sll", result, 32'h8000_0000);

    // signed mult, then mfhi/mflo right behind it
    issue(2'b10, 6'h18, 5'd0, 32'hFFFF_FFFD, 32'h7);
    check_eq("mult_ready_low", 32'(in_ready), 32'h0);
    check_eq("mult_no_valid", 32'(out_valid), 32'h0);
    wait_done(n);
    check_eq("mult_latency", n, 34);
    check_eq("mult_lo", lo, 32'hFFFF_FFEB);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_result", result, 32'hFFFF_FFEB);
    check_eq("mult_ready_high", 32'(in_ready), 32'h1);
    issue(2'b10, 6'h10, 5'd0, 32'h0, 32'h0);
    check_eq("mfhi", result, 32'hFFFF_FFFF);
    check_eq("mfhi_valid", 32'(out_valid), 32'h1);
    issue(2'b10, 6'h12, 5'd0, 32'h0, 32'h0);
    check_eq("mflo", result, 32'hFFFF_FFEB);

    // signed divide
    issue(2'b10, 6'h1A, 5'd0, 32'hFFFF_FFF9, 32'h2);
    wait_done(n);
    check_eq("div_latency", n, 34);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);
    check_eq("div_zero_flag", 32'(zero), 32'h0);

    // divu by zero with a held request while busy
    issue(2'b10, 6'h1B, 5'd0, 32'h7, 32'h0);
    ALUOp = 2'b00; Funct = 6'h00; a = 32'h1; b = 32'h1; in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("busy_ignored", 32'(out_valid), 32'h0);
    end
    in_valid = 1'b0;
    wait_done(n);
    check_eq("divu0_latency", n + 3, 34);
    check_eq("divu0_lo", lo, 32'hFFFF_FFFF);
    check_eq("divu0_hi", hi, 32'h7);
    check_eq("divu0_result", result, 32'hFFFF_FFFF);

    // unsigned mult with carry into hi
    issue(2'b10, 6'h19, 5'd0, 32'hFFFF_FFFF, 32'h2);
    wait_done(n);
    check_eq("multu_latency", n, 34);
    check_eq("multu_hi", hi, 32'h1);
    check_eq("multu_lo", lo, 32'hFFFF_FFFE);

    // illegal funct
    issue(2'b10, 6'h3F, 5'd0, 32'h1234, 32'h5678);
    check_eq("illegal_flag", 32'(illegal), 32'h1);
    check_eq("illegal_result", result, 32'h0);
    check_eq("illegal_hi", hi, 32'h1);
    check_eq("illegal_lo", lo, 32'hFFFF_FFFE);
    issue(2'b00, 6'h00, 5'd0, 32'h2, 32'h3);
    check_eq("illegal_clear", 32'(illegal), 32'h0);
    check_eq("add_small", result, 32'h5);

    // reset during a multiply
    issue(2'b10, 6'h18, 5'd0, 32'h3, 32'h5);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check_eq("abort_hi", hi, 32'h0);
    check_eq("abort_lo", lo, 32'h0);
    check_eq("abort_ready", 32'(in_ready), 32'h1);
    check_eq("abort_result", result, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) pulses++;
    end
    check_eq("abort_no_valid", pulses, 0);
    check_eq("abort_lo_after", lo, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
